// File: rtl/clk_div_ctrl.sv
// Runtime reprogramming controller for the clock divider: glitch-free ratio change via gate/drain/load/settle.
// Optional DRAIN timeout with sticky to_flag output when DIV_CTRL_TIMEOUT_EN is defined.
module clk_div_ctrl #(
  parameter int NW      = 8,
  parameter int N_MIN   = 2,
  parameter int N_MAX   = 255,
  parameter int N_RESET = 7,
  parameter int SETTLE  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [NW-1:0] req_n,
  output logic          req_ready,
  input  logic          div_clk_in,
  output logic [NW-1:0] div_n,
  output logic          div_rst,
  output logic          clk_en,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
`ifdef DIV_CTRL_TIMEOUT_EN
  ,
  output logic          to_flag
`endif
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRAIN,
    S_LOAD,
    S_SETTLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] div_n_q, div_n_d;
  logic [NW-1:0] pend_q, pend_d;
  logic          div_clk_q, div_clk_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          in_range;

  // Widened so the upper bound stays meaningful when N_MAX is the field's maximum.
  assign in_range = ({1'b0, req_n} >= (NW+1)'(N_MIN)) && ({1'b0, req_n} <= (NW+1)'(N_MAX));

`ifdef DIV_CTRL_TIMEOUT_EN
  localparam int TW = NW + 2;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_flag_q, to_flag_d;
  logic [TW-1:0] to_last;

  // Last DRAIN cycle index of a 2*div_n+2 cycle window, measured against the ratio still in force.
  assign to_last = {1'b0, div_n_q, 1'b0} + TW'(1);
`endif

  // NOTE: every combinational output and next-state variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_n_d   = div_n_q;
    pend_d    = pend_q;
    div_clk_d = div_clk_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
`ifdef DIV_CTRL_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
`endif
    req_ready = 1'b0;
    busy      = 1'b1;
    clk_en    = 1'b0;
    div_rst   = 1'b0;

    unique case (state_q)
      S_INIT: begin
        div_rst = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        clk_en    = 1'b1;
        // Cleared so a level already low on DRAIN entry cannot masquerade as a falling edge.
        div_clk_d = 1'b0;
        if (req_valid) begin
          if (!in_range) begin
            cfg_err_d = 1'b1;
          end else begin
`ifdef DIV_CTRL_TIMEOUT_EN
            to_flag_d = 1'b0;
            to_cnt_d  = '0;
`endif
            if (req_n == div_n_q) begin
              done_d = 1'b1;
            end else begin
              pend_d  = req_n;
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_DRAIN: begin
        div_clk_d = div_clk_in;
        if (div_clk_q && !div_clk_in) begin
          state_d = S_LOAD;
        end
`ifdef DIV_CTRL_TIMEOUT_EN
        else if (to_cnt_q == to_last) begin
          state_d   = S_LOAD;
          to_flag_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end

      S_LOAD: begin
        div_rst = 1'b1;
        div_n_d = pend_q;
        // The LOAD cycle is the first of the SETTLE cycles that div_rst is held.
        if (SETTLE == 1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = CW'(1);
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        div_rst = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      div_n_q   <= NW'(N_RESET);
      pend_q    <= NW'(N_RESET);
      div_clk_q <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef DIV_CTRL_TIMEOUT_EN
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_n_q   <= div_n_d;
      pend_q    <= pend_d;
      div_clk_q <= div_clk_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
`ifdef DIV_CTRL_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
`endif
    end
  end

  assign div_n   = div_n_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
`ifdef DIV_CTRL_TIMEOUT_EN
  assign to_flag = to_flag_q;
`endif

endmodule
